// File: rtl/full_st1_pkg.sv
// Shared definitions for the full_st1 tap-memory arbiter: FSM state encoding,
// burst identifier codes and the default write-to-read turnaround length.
package full_st1_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UPDATE = 3'd1,
    ST_LOAD   = 3'd2,
    ST_READ   = 3'd3,
    ST_TURN   = 3'd4
  } state_e;

  // Burst ids double as the round-robin last-granted codes
  localparam logic [1:0] DONE_ERROR = 2'd0;
  localparam logic [1:0] DONE_LOAD  = 2'd1;
  localparam logic [1:0] DONE_READ  = 2'd2;

  localparam int TURN_CYC_DEF = 2;

  function automatic logic [2:0] grant_of(input state_e st);
    logic [2:0] g;
    case (st)
      ST_UPDATE: g = 3'b001;
      ST_LOAD:   g = 3'b010;
      ST_READ:   g = 3'b100;
      default:   g = 3'b000;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/full_st1_rr_pick3.sv
// Three-way round-robin selector: starts searching just after the last-granted
// agent. req/pick bit order is {read, load, error}.
module full_st1_rr_pick3
  import full_st1_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] pick
);

  // Rotated fixed-priority search; an out-of-range last behaves like READ
  always_comb begin
    pick = 3'b000;
    case (last)
      DONE_ERROR: begin
        if (req[1])      pick = 3'b010;
        else if (req[2]) pick = 3'b100;
        else if (req[0]) pick = 3'b001;
        else             pick = 3'b000;
      end
      DONE_LOAD: begin
        if (req[2])      pick = 3'b100;
        else if (req[0]) pick = 3'b001;
        else if (req[1]) pick = 3'b010;
        else             pick = 3'b000;
      end
      default: begin
        if (req[0])      pick = 3'b001;
        else if (req[1]) pick = 3'b010;
        else if (req[2]) pick = 3'b100;
        else             pick = 3'b000;
      end
    endcase
  end

endmodule

// File: rtl/full_st1_tap_arbiter.sv
// Arbitrates the tap memory port between the error-update, input-load and
// forward-read agents, running one length-latched burst at a time.
module full_st1_tap_arbiter
  import full_st1_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int TURN_CYC = TURN_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic              error_req,
  input  logic              read_req,
  input  logic [ADDR_W-1:0] load_length,
  input  logic [ADDR_W-1:0] error_tap_length,
  input  logic [ADDR_W-1:0] read_length,
  input  logic              load_vld,
  input  logic              error_vld,
  output logic [2:0]        grant,
  output logic              load_rdy,
  output logic              error_rdy,
  output logic              read_rdy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              burst_done,
  output logic [1:0]        done_id,
  output logic              busy
);

  localparam int TURN_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'((TURN_CYC > 0) ? (TURN_CYC - 1) : 0);
  localparam logic [ADDR_W-1:0] CNT_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] CNT_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [1:0]          last_q, last_d;
  logic [TURN_W-1:0]   turn_q, turn_d;

  logic [2:0]          pick_s;
  logic                wr_vld_s;
  logic                last_beat_s;
  logic [2:0]          grant_s;
  logic                load_rdy_s, error_rdy_s, read_rdy_s;
  logic                mem_en_s, mem_we_s, done_s, busy_s;
  logic [1:0]          done_id_s;
  state_e              after_wr_s;

  full_st1_rr_pick3 u_pick (
    .req  ({read_req, load_req, error_req}),
    .last (last_q),
    .pick (pick_s)
  );

  assign wr_vld_s    = (state_q == ST_UPDATE) ? error_vld : load_vld;
  assign last_beat_s = (cnt_q == len_q);
  assign after_wr_s  = (TURN_CYC > 0) ? ST_TURN : ST_IDLE;

  // Next-state, counters and per-cycle port outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    last_d      = last_q;
    turn_d      = turn_q;
    grant_s     = grant_of(state_q);
    load_rdy_s  = 1'b0;
    error_rdy_s = 1'b0;
    read_rdy_s  = 1'b0;
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    done_s      = 1'b0;
    done_id_s   = 2'd0;
    busy_s      = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        cnt_d = CNT_ZERO;
        if (pick_s[0]) begin
          state_d = ST_UPDATE;
          len_d   = error_tap_length;
          last_d  = DONE_ERROR;
        end else if (pick_s[1]) begin
          state_d = ST_LOAD;
          len_d   = load_length;
          last_d  = DONE_LOAD;
        end else if (pick_s[2]) begin
          state_d = ST_READ;
          len_d   = read_length;
          last_d  = DONE_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_UPDATE, ST_LOAD: begin
        if (wr_vld_s) begin
          mem_en_s = 1'b1;
          mem_we_s = 1'b1;
          if (state_q == ST_UPDATE) begin
            error_rdy_s = 1'b1;
          end else begin
            load_rdy_s = 1'b1;
          end
          if (last_beat_s) begin
            done_s    = 1'b1;
            done_id_s = (state_q == ST_UPDATE) ? DONE_ERROR : DONE_LOAD;
            cnt_d     = CNT_ZERO;
            turn_d    = {TURN_W{1'b0}};
            state_d   = after_wr_s;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_READ: begin
        mem_en_s   = 1'b1;
        read_rdy_s = 1'b1;
        if (last_beat_s) begin
          done_s    = 1'b1;
          done_id_s = DONE_READ;
          cnt_d     = CNT_ZERO;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_TURN: begin
        if (turn_q == TURN_LAST) begin
          turn_d  = {TURN_W{1'b0}};
          state_d = ST_IDLE;
        end else begin
          turn_d = turn_q + {{(TURN_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      len_q   <= CNT_ZERO;
      last_q  <= DONE_READ;
      turn_q  <= {TURN_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      last_q  <= last_d;
      turn_q  <= turn_d;
    end
  end

  // Outputs are forced quiet for the whole time reset is held low
  assign grant      = reset ? grant_s     : 3'b000;
  assign load_rdy   = reset ? load_rdy_s  : 1'b0;
  assign error_rdy  = reset ? error_rdy_s : 1'b0;
  assign read_rdy   = reset ? read_rdy_s  : 1'b0;
  assign mem_en     = reset ? mem_en_s    : 1'b0;
  assign mem_we     = reset ? mem_we_s    : 1'b0;
  assign mem_addr   = reset ? cnt_q       : CNT_ZERO;
  assign burst_done = reset ? done_s      : 1'b0;
  assign done_id    = reset ? done_id_s   : 2'd0;
  assign busy       = reset ? busy_s      : 1'b0;

endmodule

// File: tb/tb_full_st1_tap_arbiter.sv
// Randomized bench for full_st1_tap_arbiter against a transaction-level model
// that tracks phase, current agent, beats taken and turnaround left.
module tb_full_st1_tap_arbiter;

  localparam int AW = 4;
  localparam int TC = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_req, error_req, read_req;
  logic [AW-1:0] load_length, error_tap_length, read_length;
  logic          load_vld, error_vld;
  logic [2:0]    grant;
  logic          load_rdy, error_rdy, read_rdy;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic          burst_done;
  logic [1:0]    done_id;
  logic          busy;

  always #5 clk = ~clk;

  full_st1_tap_arbiter #(.ADDR_W(AW), .TURN_CYC(TC)) dut (
    .clk(clk), .reset(reset),
    .load_req(load_req), .error_req(error_req), .read_req(read_req),
    .load_length(load_length), .error_tap_length(error_tap_length), .read_length(read_length),
    .load_vld(load_vld), .error_vld(error_vld),
    .grant(grant), .load_rdy(load_rdy), .error_rdy(error_rdy), .read_rdy(read_rdy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .burst_done(burst_done), .done_id(done_id), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;

  // Model: phase 0 idle, 1 burst, 2 turnaround; who 0 error, 1 load, 2 read
  int m_phase = 0, m_who = 0, m_beat = 0, m_len = 0, m_last = 2, m_turn = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    int req[3];
    int lenv[3];
    int vld[3];
    int e_grant, e_lrdy, e_erdy, e_rrdy, e_en, e_we, e_addr, e_done, e_id, e_busy;
    bit beat;
    req[0] = int'(error_req);  req[1] = int'(load_req);    req[2] = int'(read_req);
    lenv[0] = int'(error_tap_length); lenv[1] = int'(load_length); lenv[2] = int'(read_length);
    vld[0] = int'(error_vld);  vld[1] = int'(load_vld);    vld[2] = 1;
    e_grant = 0; e_lrdy = 0; e_erdy = 0; e_rrdy = 0; e_en = 0; e_we = 0;
    e_done = 0; e_id = 0; e_busy = 0; e_addr = 0;
    beat = 1'b0;
    if (reset) begin
      e_addr = m_beat;
      e_busy = (m_phase != 0) ? 1 : 0;
      if (m_phase == 1) begin
        e_grant = 1 << m_who;
        beat = (vld[m_who] != 0);
        if (beat) begin
          e_en = 1;
          e_we = (m_who != 2) ? 1 : 0;
          if (m_who == 0) e_erdy = 1;
          if (m_who == 1) e_lrdy = 1;
          if (m_who == 2) e_rrdy = 1;
          if (m_beat == m_len) begin
            e_done = 1;
            e_id = m_who;
          end
        end
      end
    end
    @(negedge clk);
    check_val("grant",      32'(grant),      32'(e_grant));
    check_val("load_rdy",   32'(load_rdy),   32'(e_lrdy));
    check_val("error_rdy",  32'(error_rdy),  32'(e_erdy));
    check_val("read_rdy",   32'(read_rdy),   32'(e_rrdy));
    check_val("mem_en",     32'(mem_en),     32'(e_en));
    check_val("mem_we",     32'(mem_we),     32'(e_we));
    check_val("mem_addr",   32'(mem_addr),   32'(e_addr));
    check_val("burst_done", 32'(burst_done), 32'(e_done));
    check_val("done_id",    32'(done_id),    32'(e_id));
    check_val("busy",       32'(busy),       32'(e_busy));
    if (burst_done === 1'b1) n_done++;
    @(posedge clk);
    if (!reset) begin
      m_phase = 0; m_beat = 0; m_len = 0; m_last = 2; m_turn = 0;
    end else if (m_phase == 0) begin
      for (int k = 1; k <= 3; k++) begin
        int w;
        w = (m_last + k) % 3;
        if (m_phase == 0 && req[w] != 0) begin
          m_phase = 1; m_who = w; m_last = w; m_len = lenv[w]; m_beat = 0;
        end
      end
    end else if (m_phase == 1) begin
      if (beat) begin
        if (m_beat == m_len) begin
          m_beat = 0;
          if (m_who == 2 || TC == 0) m_phase = 0;
          else begin
            m_phase = 2;
            m_turn = TC;
          end
        end else begin
          m_beat++;
        end
      end
    end else begin
      m_turn--;
      if (m_turn == 0) m_phase = 0;
    end
    #1;
  endtask

  task automatic quiet();
    load_req = 1'b0; error_req = 1'b0; read_req = 1'b0;
    load_vld = 1'b0; error_vld = 1'b0;
    load_length = 4'd0; error_tap_length = 4'd0; read_length = 4'd0;
  endtask

  initial begin
    int d0;
    reset = 1'b0;
    quiet();
    @(posedge clk); #1;
    // Held reset with busy-looking inputs must keep all outputs zero
    error_req = 1'b1; load_req = 1'b1; read_req = 1'b1; error_vld = 1'b1; load_vld = 1'b1;
    repeat (3) cycle();
    quiet();

    // Error burst of 4 beats, then turnaround
    reset = 1'b1;
    error_req = 1'b1; error_tap_length = 4'd3; error_vld = 1'b1;
    d0 = n_done;
    repeat (6) cycle();
    check_val("err_burst_done_count", 32'(n_done - d0), 32'd1);
    error_req = 1'b0;
    repeat (4) cycle();

    // All three requesters held high: round-robin rotation
    error_req = 1'b1; load_req = 1'b1; read_req = 1'b1;
    error_vld = 1'b1; load_vld = 1'b1;
    error_tap_length = 4'd1; load_length = 4'd2; read_length = 4'd3;
    repeat (30) cycle();
    quiet();
    repeat (6) cycle();

    // Load with stuttering valid
    load_req = 1'b1; load_length = 4'd2;
    cycle();
    load_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_vld = (i % 2 == 0) ? 1'b1 : 1'b0;
      load_length = 4'($urandom_range(0, 15));
      cycle();
    end
    load_vld = 1'b0;
    repeat (4) cycle();

    // One-cycle read pulse, 6 beats, no turnaround
    read_req = 1'b1; read_length = 4'd5;
    cycle();
    read_req = 1'b0;
    repeat (8) cycle();

    // Reset in the middle of an 8-beat load, then a contended request
    load_req = 1'b1; load_length = 4'd7; load_vld = 1'b1;
    repeat (3) cycle();
    d0 = n_done;
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    check_val("no_done_after_abort", 32'(n_done - d0), 32'd0);
    error_req = 1'b1; error_vld = 1'b1; error_tap_length = 4'd0;
    cycle();
    error_req = 1'b0; load_req = 1'b0;
    repeat (6) cycle();
    quiet();

    // Maximum-length read
    read_req = 1'b1; read_length = 4'd15;
    cycle();
    read_req = 1'b0;
    d0 = n_done;
    repeat (18) cycle();
    check_val("max_read_done_count", 32'(n_done - d0), 32'd1);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      reset            = ($urandom_range(0, 299) != 0);
      error_req        = ($urandom_range(0, 3) == 0);
      load_req         = ($urandom_range(0, 3) == 0);
      read_req         = ($urandom_range(0, 3) == 0);
      error_vld        = ($urandom_range(0, 2) != 0);
      load_vld         = ($urandom_range(0, 2) != 0);
      error_tap_length = 4'($urandom_range(0, 15));
      load_length      = 4'($urandom_range(0, 15));
      read_length      = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/full_st1_tap_arbiter.md
FULL_ST1_TAP_ARBITER -- requirements
Module: full_st1_tap_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, tap memory address width.
REQ-002 The block SHALL have parameter TURN_CYC, default 2, idle cycles after any write burst.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-low; reset==0 at a clk edge resets the block.
REQ-005 load_req, error_req, read_req  in  1 each  level burst requests from the input-load, error-update and forward-read agents.
REQ-006 load_length, error_tap_length, read_length  in  ADDR_W each  last address of the respective burst.
REQ-007 load_vld, error_vld  in  1 each  write beat offered by the granted writer.
REQ-008 grant  out  3  one-hot {read, load, error}; all-zero when idle.
REQ-009 load_rdy, error_rdy, read_rdy  out  1 each  beat accepted this cycle.
REQ-010 mem_en, mem_we  out  1 each; mem_addr  out  ADDR_W  tap memory port.
REQ-011 burst_done  out  1  one-cycle pulse on the last beat; done_id  out  2  (0 error, 1 load, 2 read) valid with burst_done.
REQ-012 busy  out  1  high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, UPDATE, LOAD, READ, TURN.
REQ-014 In IDLE with any request high, the next state SHALL be the first requester in round-robin order after the last-granted one; grant rises the cycle after the request is sampled.
REQ-015 After reset the last-granted pointer SHALL be READ, so the initial priority is UPDATE > LOAD > READ.
REQ-016 On grant, the respective length SHALL be latched; length changes mid-burst have no effect.
REQ-017 The beat counter SHALL start at 0 on grant and drive mem_addr.
REQ-018 In UPDATE/LOAD, a beat occurs when the matching vld is high: mem_en=mem_we=1 and rdy=1, all combinational from state and vld.
REQ-019 In READ, a beat SHALL occur every cycle: mem_en=1, mem_we=0, read_rdy=1.
REQ-020 A burst SHALL comprise latched_length+1 beats; length 0 gives a single beat.
REQ-021 On the beat where counter equals the latched length: burst_done=1, done_id set, counter cleared.
REQ-022 After burst_done, UPDATE/LOAD SHALL go to TURN and READ SHALL go to IDLE.
REQ-023 TURN SHALL last exactly TURN_CYC cycles with grant=0 and mem_en=0, then return to IDLE.
REQ-024 A request dropped mid-burst SHALL not abort the burst; requests are only sampled in IDLE.
REQ-025 Outside beats, mem_en=0, mem_we=0 and all rdy=0; mem_addr SHALL hold the counter value.
REQ-026 Counter arithmetic SHALL be ADDR_W-bit unsigned; the maximum length (all ones) SHALL complete without wrap ambiguity.

Reset
REQ-027 Under reset: state=IDLE, counter=0, latched lengths=0, last-granted=READ, TURN counter=0.
REQ-028 Under reset, all outputs SHALL be 0.
REQ-029 Reset asserted mid-burst SHALL drop the burst with no burst_done; the first post-reset grant follows REQ-015.

Structure
REQ-030 The state encoding and the done_id codes SHALL live in the shared full_st1 package, together with the TURN_CYC default.
REQ-031 The round-robin selector SHALL be one sub-module, full_st1_rr_pick3 (3 requests plus last-granted in, one-hot pick out, combinational).

Verification
REQ-032 Scenario: reset release, error_req=1, error_tap_length=3, error_vld=1 constant -> grant=001 one cycle later; mem_addr 0,1,2,3 with mem_we=1; burst_done with done_id=0 on addr 3; then 2 cycles with mem_en=0.
REQ-033 Scenario: all three requests held high -> grant order UPDATE, LOAD, READ, UPDATE; each burst separated per REQ-022/023.
REQ-034 Scenario: LOAD, load_length=2, load_vld toggling 1,0,1,0,1 -> beats only on vld-high cycles at addrs 0,1,2; burst_done on the 5th cycle.
REQ-035 Scenario: read_req pulsed for 1 cycle, read_length=5 -> 6 consecutive read beats at addrs 0..5, then IDLE with no TURN.
REQ-036 Scenario: reset driven low at beat 2 of an 8-beat LOAD -> next cycle all outputs 0, no burst_done; a new request with load_req and error_req both high is granted to UPDATE.
REQ-037 Scenario: read_length=15 with ADDR_W=4 -> 16 beats, addr 15 last, burst_done once, counter back to 0.
